// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, framing/break/overrun detection and an FWFT receive FIFO.
// Define UART_RX_PARITY_EN to compile in a parity bit after the data (even, or odd with PARITY_ODD=1).
module uart_rx_fifo #(
    parameter int CLK_HZ       = 27_000_000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          uart_rxd,
    input  logic                          uart_rx_en,
    output logic [PAYLOAD_BITS-1:0]       rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          rx_busy,
    output logic                          err_frame,
    output logic                          err_parity,
    output logic                          err_overrun,
    output logic                          rx_break
);
    localparam int CPB = CLK_HZ / BIT_RATE;
    localparam int CW  = $clog2(CPB);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] C_LO  = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] C_MID = CW'(CPB / 2);
    localparam logic [CW-1:0] C_HI  = CW'(CPB / 2 + 1);
    localparam logic [CW-1:0] C_END = CW'(CPB - 1);
    localparam logic [AW:0]   FULL  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BRK_WAIT
    } state_t;

    state_t                  state;
    logic                    sync0, rxs;
    logic [CW-1:0]           cnt;
    logic [3:0]              bit_cnt;
    logic                    stop_cnt;
    logic                    s0, s1, bit_val;
    logic [PAYLOAD_BITS-1:0] shreg;
    logic                    stop_low, first_stop_low;
    logic                    par_bad;

    logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;

    logic maj, at_hi, at_end, final_stop, first_low, any_low, data_zero;
    logic is_break, is_frame, is_par, push, pop, full, wr_en, overrun;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync0 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync0 <= uart_rxd;
            rxs   <= sync0;
        end
    end

    // The third vote is the live synchronised sample at the CPB/2+1 point.
    assign maj        = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
    assign at_hi      = (cnt == C_HI);
    assign at_end     = (cnt == C_END);
    assign final_stop = (state == STOP) && at_hi && (stop_cnt == 1'(STOP_BITS - 1));
    assign first_low  = (STOP_BITS == 1) ? !maj : first_stop_low;
    assign any_low    = stop_low | !maj;
    assign data_zero  = (shreg == '0);
    assign is_break   = final_stop && data_zero && first_low;
    assign is_frame   = final_stop && any_low;
    assign is_par     = final_stop && !any_low && par_bad;
    assign push       = final_stop && !any_low && !par_bad;
    assign pop        = rd_valid && rd_ready;
    assign full       = (fifo_count == FULL);
    assign wr_en      = push && (!full || pop);
    assign overrun    = push && full && !pop;

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!resetn)
            par_bad <= 1'b0;
        else if (state == PARITY && at_end)
            par_bad <= (^shreg) ^ bit_val ^ 1'(PARITY_ODD);
    end
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= IDLE;
            cnt            <= '0;
            bit_cnt        <= '0;
            stop_cnt       <= 1'b0;
            s0             <= 1'b1;
            s1             <= 1'b1;
            bit_val        <= 1'b1;
            shreg          <= '0;
            stop_low       <= 1'b0;
            first_stop_low <= 1'b0;
            err_frame      <= 1'b0;
            err_parity     <= 1'b0;
            err_overrun    <= 1'b0;
            rx_break       <= 1'b0;
        end else begin
            err_frame   <= is_frame;
            err_parity  <= is_par;
            err_overrun <= overrun;
            rx_break    <= is_break;
            if (state != IDLE) cnt <= at_end ? '0 : cnt + 1'b1;
            if (cnt == C_LO)   s0 <= rxs;
            if (cnt == C_MID)  s1 <= rxs;
            if (at_hi)         bit_val <= maj;
            case (state)
                IDLE: begin
                    cnt      <= '0;
                    bit_cnt  <= '0;
                    stop_cnt <= 1'b0;
                    stop_low <= 1'b0;
                    if (!rxs && uart_rx_en) state <= START;
                end
                START: begin
                    if (at_hi && maj)  state <= IDLE;
                    else if (at_end)   state <= DATA;
                end
                DATA: begin
                    if (at_end) begin
                        shreg   <= {bit_val, shreg[PAYLOAD_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'(PAYLOAD_BITS - 1))
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (at_end) state <= STOP;
`endif
                STOP: begin
                    // Final stop bit resolves at its majority point to regain half a bit for resync.
                    if (final_stop) begin
                        state <= is_break ? BRK_WAIT : IDLE;
                    end else if (at_end) begin
                        stop_cnt       <= stop_cnt + 1'b1;
                        first_stop_low <= !bit_val;
                        stop_low       <= stop_low | !bit_val;
                    end
                end
                BRK_WAIT: if (rxs) state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign rd_valid = (fifo_count != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
    assign rx_busy  = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at CPB=10, FIFO_DEPTH=8, 8N1 (plus a parity bit when UART_RX_PARITY_EN is set).
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int CLK_HZ     = 1_000_000;
    localparam int BIT_RATE   = 100_000;
    localparam int CPB        = 10;
    localparam int FIFO_DEPTH = 8;
    localparam int PB         = 8;
    localparam int PARITY_ODD = 0;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       uart_rx_en = 1'b1;
    logic       rd_ready = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [3:0] fifo_count;
    logic       rx_busy, err_frame, err_parity, err_overrun, rx_break;

    int n_checks = 0;
    int n_pass = 0;
    int n_frame = 0, n_break = 0, n_par = 0, n_ovr = 0;
    bit busy_seen = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(PB),
        .STOP_BITS(1), .FIFO_DEPTH(FIFO_DEPTH), .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk(clk), .resetn(resetn), .uart_rxd(uart_rxd), .uart_rx_en(uart_rx_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .fifo_count(fifo_count), .rx_busy(rx_busy), .err_frame(err_frame),
        .err_parity(err_parity), .err_overrun(err_overrun), .rx_break(rx_break)
    );

    // Pulse counters sampled shortly after each active edge.
    always @(posedge clk) begin
        #2;
        if (err_frame)   n_frame++;
        if (rx_break)    n_break++;
        if (err_parity)  n_par++;
        if (err_overrun) n_ovr++;
        if (rx_busy)     busy_seen = 1'b1;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bit period; optional single-cycle inversion at offset 6 and rd_ready in the last cycle.
    task automatic send_bit(input logic v, input bit inv, input bit pop);
        for (int w = 0; w < CPB; w++) begin
            uart_rxd = (inv && w == 6) ? ~v : v;
            rd_ready = pop && (w == CPB - 1);
            @(negedge clk);
        end
        rd_ready = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_val, input bit par_bad,
                              input int inv_bit, input bit pop_at_stop);
        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < PB; i++) send_bit(data[i], i == inv_bit, 1'b0);
`ifdef UART_RX_PARITY_EN
        send_bit((^data) ^ 1'(PARITY_ODD) ^ par_bad, 1'b0, 1'b0);
`endif
        send_bit(stop_val, 1'b0, pop_at_stop);
        uart_rxd = 1'b1;
    endtask

    task automatic do_pop();
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle(4);
        resetn = 1'b1;
        idle(3);
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", rd_valid); else n_pass++;
        n_checks++; if (fifo_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", fifo_count); else n_pass++;
        n_checks++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h want 00", rd_data); else n_pass++;
        n_checks++; if (rx_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", rx_busy); else n_pass++;
        n_checks++;
        if ({err_frame, err_parity, err_overrun, rx_break} !== 4'b0000)
            $display("FAIL reset_pulses: got %b want 0000", {err_frame, err_parity, err_overrun, rx_break});
        else n_pass++;
    endtask

    task automatic test_single();
        send_frame(8'h55, 1'b1, 1'b0, -1, 1'b0);
        idle(2);
        n_checks++; if (rd_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", rd_valid); else n_pass++;
        n_checks++; if (rd_data !== 8'h55) $display("FAIL single_data: got %h want 55", rd_data); else n_pass++;
        n_checks++; if (fifo_count !== 4'd1) $display("FAIL single_count: got %0d want 1", fifo_count); else n_pass++;
        do_pop();
        n_checks++; if (fifo_count !== 4'd0) $display("FAIL single_pop_count: got %0d want 0", fifo_count); else n_pass++;
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL single_pop_valid: got %b want 0", rd_valid); else n_pass++;
    endtask

    task automatic test_overrun();
        int ovr0;
        ovr0 = n_ovr;
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1, 1'b0, -1, 1'b0);
        n_checks++; if (n_ovr - ovr0 !== 0) $display("FAIL ovr_before_9: got %0d want 0", n_ovr - ovr0); else n_pass++;
        send_frame(8'h09, 1'b1, 1'b0, -1, 1'b0);
        idle(2);
        n_checks++; if (n_ovr - ovr0 !== 1) $display("FAIL ovr_pulses: got %0d want 1", n_ovr - ovr0); else n_pass++;
        n_checks++; if (fifo_count !== 4'd8) $display("FAIL ovr_count: got %0d want 8", fifo_count); else n_pass++;
        for (int i = 1; i <= 8; i++) begin
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== 8'(i))
                $display("FAIL ovr_read_%0d: got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, 8'(i));
            else n_pass++;
            do_pop();
        end
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL ovr_drained: got %b want 0", rd_valid); else n_pass++;
    endtask

    task automatic test_full_push_pop();
        int ovr0;
        ovr0 = n_ovr;
        for (int i = 0; i < 8; i++) send_frame(8'h21 + 8'(i), 1'b1, 1'b0, -1, 1'b0);
        send_frame(8'h29, 1'b1, 1'b0, -1, 1'b1);
        idle(2);
        n_checks++; if (fifo_count !== 4'd8) $display("FAIL full_pp_count: got %0d want 8", fifo_count); else n_pass++;
        n_checks++; if (n_ovr - ovr0 !== 0) $display("FAIL full_pp_ovr: got %0d want 0", n_ovr - ovr0); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (rd_data !== 8'h22 + 8'(i))
                $display("FAIL full_pp_read_%0d: got %h want %h", i, rd_data, 8'h22 + 8'(i));
            else n_pass++;
            do_pop();
        end
        n_checks++; if (fifo_count !== 4'd0) $display("FAIL full_pp_empty: got %0d want 0", fifo_count); else n_pass++;
    endtask

    task automatic test_frame_err();
        int fr0, br0;
        fr0 = n_frame;
        br0 = n_break;
        send_frame(8'hA3, 1'b0, 1'b0, -1, 1'b0);
        idle(20);
        n_checks++; if (n_frame - fr0 !== 1) $display("FAIL ferr_pulses: got %0d want 1", n_frame - fr0); else n_pass++;
        n_checks++; if (n_break - br0 !== 0) $display("FAIL ferr_break: got %0d want 0", n_break - br0); else n_pass++;
        n_checks++; if (fifo_count !== 4'd0) $display("FAIL ferr_count: got %0d want 0", fifo_count); else n_pass++;
        n_checks++; if (rx_busy !== 1'b0) $display("FAIL ferr_idle: got %b want 0", rx_busy); else n_pass++;
    endtask

    task automatic test_break();
        int fr0, br0;
        fr0 = n_frame;
        br0 = n_break;
        uart_rxd = 1'b0;
        idle(20 * CPB);
        n_checks++; if (n_break - br0 !== 1) $display("FAIL brk_pulses: got %0d want 1", n_break - br0); else n_pass++;
        n_checks++; if (n_frame - fr0 !== 1) $display("FAIL brk_frame: got %0d want 1", n_frame - fr0); else n_pass++;
        n_checks++; if (rx_busy !== 1'b1) $display("FAIL brk_busy_low: got %b want 1", rx_busy); else n_pass++;
        uart_rxd = 1'b1;
        idle(5);
        n_checks++; if (rx_busy !== 1'b0) $display("FAIL brk_busy_high: got %b want 0", rx_busy); else n_pass++;
        send_frame(8'h3C, 1'b1, 1'b0, -1, 1'b0);
        idle(1);
        n_checks++; if (rd_data !== 8'h3C) $display("FAIL brk_next_data: got %h want 3c", rd_data); else n_pass++;
        do_pop();
    endtask

    task automatic test_glitch_majority();
        int fr0;
        fr0 = n_frame + n_break + n_par + n_ovr;
        uart_rxd = 1'b0;
        idle(2);
        uart_rxd = 1'b1;
        n_checks++; if (rx_busy !== 1'b0) $display("FAIL glitch_busy_early: got %b want 0", rx_busy); else n_pass++;
        idle(1);
        n_checks++; if (rx_busy !== 1'b1) $display("FAIL glitch_busy_latency: got %b want 1", rx_busy); else n_pass++;
        idle(9);
        n_checks++; if (rx_busy !== 1'b0) $display("FAIL glitch_busy_drop: got %b want 0", rx_busy); else n_pass++;
        n_checks++; if (fifo_count !== 4'd0) $display("FAIL glitch_count: got %0d want 0", fifo_count); else n_pass++;
        n_checks++;
        if (n_frame + n_break + n_par + n_ovr - fr0 !== 0)
            $display("FAIL glitch_pulses: got %0d want 0", n_frame + n_break + n_par + n_ovr - fr0);
        else n_pass++;
        send_frame(8'hF0, 1'b1, 1'b0, 4, 1'b0);
        send_frame(8'hF0, 1'b1, 1'b0, 0, 1'b0);
        idle(1);
        n_checks++; if (fifo_count !== 4'd2) $display("FAIL maj_count: got %0d want 2", fifo_count); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (rd_data !== 8'hF0) $display("FAIL maj_data_%0d: got %h want f0", i, rd_data); else n_pass++;
            do_pop();
        end
    endtask

    task automatic test_rx_disable();
        uart_rx_en = 1'b0;
        idle(1);
        busy_seen = 1'b0;
        send_frame(8'h5A, 1'b1, 1'b0, -1, 1'b0);
        idle(3);
        n_checks++; if (busy_seen !== 1'b0) $display("FAIL rxen_busy: got %b want 0", busy_seen); else n_pass++;
        n_checks++; if (fifo_count !== 4'd0) $display("FAIL rxen_count: got %0d want 0", fifo_count); else n_pass++;
        uart_rx_en = 1'b1;
        idle(2);
    endtask

    task automatic test_reset_mid_frame();
        int pulses0;
        send_frame(8'h11, 1'b1, 1'b0, -1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        pulses0 = n_frame + n_break + n_par + n_ovr;
        resetn = 1'b0;
        uart_rxd = 1'b1;
        idle(1);
        n_checks++; if (fifo_count !== 4'd0) $display("FAIL rst_mid_count: got %0d want 0", fifo_count); else n_pass++;
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", rd_valid); else n_pass++;
        n_checks++; if (rd_data !== 8'h00) $display("FAIL rst_mid_data: got %h want 00", rd_data); else n_pass++;
        n_checks++; if (rx_busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", rx_busy); else n_pass++;
        resetn = 1'b1;
        idle(5);
        send_frame(8'h99, 1'b1, 1'b0, -1, 1'b0);
        idle(1);
        n_checks++; if (rd_data !== 8'h99) $display("FAIL rst_next_data: got %h want 99", rd_data); else n_pass++;
        n_checks++; if (fifo_count !== 4'd1) $display("FAIL rst_next_count: got %0d want 1", fifo_count); else n_pass++;
        n_checks++;
        if (n_frame + n_break + n_par + n_ovr - pulses0 !== 0)
            $display("FAIL rst_pulses: got %0d want 0", n_frame + n_break + n_par + n_ovr - pulses0);
        else n_pass++;
        do_pop();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int par0;
        par0 = n_par;
        send_frame(8'h07, 1'b1, 1'b1, -1, 1'b0);
        idle(2);
        n_checks++; if (n_par - par0 !== 1) $display("FAIL par_bad_pulse: got %0d want 1", n_par - par0); else n_pass++;
        n_checks++; if (fifo_count !== 4'd0) $display("FAIL par_bad_count: got %0d want 0", fifo_count); else n_pass++;
        send_frame(8'h07, 1'b1, 1'b0, -1, 1'b0);
        idle(2);
        n_checks++; if (n_par - par0 !== 1) $display("FAIL par_good_pulse: got %0d want 1", n_par - par0); else n_pass++;
        n_checks++; if (rd_data !== 8'h07) $display("FAIL par_good_data: got %h want 07", rd_data); else n_pass++;
        do_pop();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_overrun();
        test_full_push_pop();
        test_frame_err();
        test_break();
        test_glitch_majority();
        test_rx_disable();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
